// File: rtl/serial_tx_if.sv
// Byte-request / serial-line bundle for serial_tx.
// The master side supplies bytes; the slave side is the transmitter.
interface serial_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_out;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_out,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_out,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/serial_tx.sv
// Serial transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Every output is registered, so each one is derived from the next-state values.
module serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          PARITY_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    serial_tx_if.slave  bus
);

    localparam int unsigned   CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    idx, idx_next;
    logic [7:0]    shreg, shreg_next;
    logic          out_next, done_next, bit_end;
    logic          out_q, ready_q, busy_q, done_q;

    assign bus.tx_out   = out_q;
    assign bus.tx_ready = ready_q;
    assign bus.tx_busy  = busy_q;
    assign bus.tx_done  = done_q;

    assign bit_end = (cnt == CNT_LAST);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shreg_next = shreg;
        done_next  = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.tx_valid && ready_q) begin
                    state_next = START;
                    cnt_next   = '0;
                    idx_next   = '0;
                    shreg_next = bus.tx_data;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_next = '0;
                    if (idx == 3'd7) begin
                        idx_next   = '0;
                        state_next = PARITY_EN ? PARITY : STOP;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Line level is a function of where the FSM will be next cycle.
        unique case (state_next)
            START:   out_next = 1'b0;
            DATA:    out_next = shreg_next[idx_next];
            PARITY:  out_next = ^shreg_next;
            default: out_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            out_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            idx     <= idx_next;
            shreg   <= shreg_next;
            out_q   <= out_next;
            ready_q <= (state_next == IDLE);
            busy_q  <= (state_next != IDLE);
            done_q  <= done_next;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (4 clk/bit with parity, 1 clk/bit without),
// fixed frame tables, hand-built corner sequences and randomized frames vs. a frame model.
module tb_serial_tx;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_tx_if ifa();
    serial_tx_if ifb();

    serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    serial_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;   // frame[i] = i-th line bit after acceptance
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int cur      = 0;         // 0 selects dut_a, 1 selects dut_b

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // {tx_out, tx_ready, tx_busy, tx_done} of the selected instance
    function automatic logic [3:0] obs();
        if (cur == 0) return {ifa.tx_out, ifa.tx_ready, ifa.tx_busy, ifa.tx_done};
        return {ifb.tx_out, ifb.tx_ready, ifb.tx_busy, ifb.tx_done};
    endfunction

    task automatic drive(input logic v, input logic [7:0] d);
        if (cur == 0) begin
            ifa.tx_valid = v;
            ifa.tx_data  = d;
        end else begin
            ifb.tx_valid = v;
            ifb.tx_data  = d;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        logic [3:0] s;
        s = obs();
        chk({tag, "_out"},   s[3], 1'b1);
        chk({tag, "_ready"}, s[2], 1'b1);
        chk({tag, "_busy"},  s[1], 1'b0);
        chk({tag, "_done"},  s[0], 1'b0);
    endtask

    // Expected line bits computed from the framing rules with plain arithmetic.
    function automatic logic [10:0] model_frame(input logic [7:0] d, input bit par_en);
        logic [10:0] f;
        int v, b, ones;
        f    = '0;
        v    = int'(d);
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b = (v / (1 << i)) % 2;
            ones += b;
            f[1 + i] = (b == 1);
        end
        if (par_en) begin
            f[9]  = ((ones % 2) == 1);
            f[10] = 1'b1;
        end else begin
            f[9] = 1'b1;
        end
        return f;
    endfunction

    // Present one byte, check every line cycle, then the tx_done cycle.
    // keep: leave tx_valid high with next_data so the next frame starts on tx_done.
    task automatic run_frame(input logic [7:0] data, input logic [10:0] frame,
                             input int nbits, input int cpb, input bit keep,
                             input logic [7:0] next_data, input bit noisy,
                             input string tag);
        logic [3:0] s;
        int waited;
        bit last;
        waited = 0;
        s = obs();
        while (s[2] == 1'b0 && waited < 300) begin
            step();
            waited++;
            s = obs();
        end
        chk({tag, "_ready_wait"}, s[2], 1'b1);
        drive(1'b1, data);
        step();
        if (keep) drive(1'b1, next_data);
        else      drive(1'b0, data);
        for (int i = 0; i < nbits; i++) begin
            for (int k = 0; k < cpb; k++) begin
                s = obs();
                chk($sformatf("%s_bit%0d", tag, i), s[3], frame[i]);
                chk({tag, "_busy"},  s[1], 1'b1);
                chk({tag, "_ready"}, s[2], 1'b0);
                chk({tag, "_done"},  s[0], 1'b0);
                last = (i == nbits - 1) && (k == cpb - 1);
                if (!keep) begin
                    if (noisy && !last) drive(1'($urandom_range(0, 1)), 8'($urandom));
                    else                drive(1'b0, data);
                end
                step();
            end
        end
        s = obs();
        chk({tag, "_done_pulse"}, s[0], 1'b1);
        chk({tag, "_done_ready"}, s[2], 1'b1);
        chk({tag, "_done_busy"},  s[1], 1'b0);
        chk({tag, "_done_out"},   s[3], 1'b1);
        if (!keep) begin
            step();
            s = obs();
            chk({tag, "_post_done"},  s[0], 1'b0);
            chk({tag, "_post_out"},   s[3], 1'b1);
            chk({tag, "_post_ready"}, s[2], 1'b1);
        end
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl_a[7];
        vec_t       tbl_b[3];
        logic [3:0] s;
        logic [7:0] d, nd;
        bit         kp;

        tbl_a[0] = '{8'hA5, 11'b101_0100_1010};
        tbl_a[1] = '{8'h01, 11'b110_0000_0010};
        tbl_a[2] = '{8'hFF, 11'b101_1111_1110};
        tbl_a[3] = '{8'h00, 11'b100_0000_0000};
        tbl_a[4] = '{8'h3C, 11'b100_0111_1000};
        tbl_a[5] = '{8'h55, 11'b100_1010_1010};
        tbl_a[6] = '{8'h07, 11'b110_0000_1110};
        tbl_b[0] = '{8'h80, 11'b011_0000_0000};
        tbl_b[1] = '{8'h3C, 11'b010_0111_1000};
        tbl_b[2] = '{8'hFF, 11'b011_1111_1110};

        reset = 1'b0;
        ifa.tx_valid = 1'b0; ifa.tx_data = '0;
        ifb.tx_valid = 1'b0; ifb.tx_data = '0;
        repeat (3) step();
        cur = 0; check_idle("rst_a");
        cur = 1; check_idle("rst_b");

        // Reset held with a pending request: nothing may be accepted.
        cur = 0; drive(1'b1, 8'hA5);
        cur = 1; drive(1'b1, 8'h5A);
        repeat (8) begin
            step();
            cur = 0; check_idle("rst_hold_a");
            cur = 1; check_idle("rst_hold_b");
        end
        cur = 0; drive(1'b0, 8'h00);
        cur = 1; drive(1'b0, 8'h00);
        reset = 1'b1;
        step();

        cur = 0;
        foreach (tbl_a[i])
            run_frame(tbl_a[i].data, tbl_a[i].frame, 11, 4, 1'b0, 8'h00, 1'b1, "tbl_a");

        run_frame(8'h01, 11'b110_0000_0010, 11, 4, 1'b1, 8'hFF, 1'b0, "b2b_first");
        run_frame(8'hFF, 11'b101_1111_1110, 11, 4, 1'b0, 8'h00, 1'b0, "b2b_second");

        // Abort 0x3C in the middle of data bit 3 (line cycles 17..20).
        drive(1'b1, 8'h3C);
        step();
        drive(1'b0, 8'h3C);
        repeat (17) step();
        s = obs();
        chk("abort_pre_out",  s[3], 1'b1);
        chk("abort_pre_busy", s[1], 1'b1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_idle("abort_post");
        repeat (60) begin
            step();
            s = obs();
            chk("abort_no_done", s[0], 1'b0);
            chk("abort_idle_out", s[3], 1'b1);
        end
        run_frame(8'h55, 11'b100_1010_1010, 11, 4, 1'b0, 8'h00, 1'b0, "after_abort");

        d = 8'($urandom);
        for (int j = 0; j < 20; j++) begin
            nd = 8'($urandom);
            kp = (j < 19) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_frame(d, model_frame(d, 1'b1), 11, 4, kp, nd, 1'b1, "rand_a");
            d = nd;
        end

        cur = 1;
        foreach (tbl_b[i])
            run_frame(tbl_b[i].data, tbl_b[i].frame, 10, 1, 1'b0, 8'h00, 1'b1, "tbl_b");

        d = 8'($urandom);
        for (int j = 0; j < 20; j++) begin
            nd = 8'($urandom);
            kp = (j < 19) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_frame(d, model_frame(d, 1'b0), 10, 1, kp, nd, 1'b1, "rand_b");
            d = nd;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
